// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Bus widths for register addresses and write data, plus the conventional
// requester slot numbers used by the writeback sources.
package rf_wb_arbiter_pkg;

  localparam int unsigned GenbusW  = 5;   // register address width
  localparam int unsigned DatabusW = 32;  // register data width

  // Requester slot assignment
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  typedef logic [GenbusW-1:0]  reg_addr_t;
  typedef logic [DatabusW-1:0] reg_data_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Scans req_i starting at ptr_i and wrapping modulo N. The first set bit wins.
//   req_i  : request vector
//   ptr_i  : highest-priority index this cycle (must be < N)
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : encoded index of the grant (0 when no request)
//   any_o  : some request was granted
module rf_wb_arbiter_rr_arbiter #(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned     pos;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = 32'(ptr_i) + off;
      if (pos >= N) pos = pos - N;
      cand = IdxW'(pos);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter.
// Shares the single RF write port among N_REQ writeback sources using a
// valid/ready handshake with round-robin priority. The write port outputs are
// registered (one cycle after the transfer). Also counts cycles in which more
// than one requester was pending (saturating).
//   clk, rst           : clock, asynchronous active-high reset
//   flush_i, stall_i   : suppress this cycle's grant
//   req_valid_i/addr_i/data_i : per-requester write request, packed by index
//   req_ready_o        : one-hot grant, transfer = valid & ready
//   rf_wen_o/waddr_o/wdata_o  : registered RF write port
//   grant_id_o         : requester behind the current registered write
//   conflict_cnt_o     : saturating count of multi-requester cycles
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        stall_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [GenbusW*N_REQ-1:0]    req_addr_i,
  input  logic [DatabusW*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic                        rf_wen_o,
  output logic [GenbusW-1:0]          rf_waddr_o,
  output logic [DatabusW-1:0]         rf_wdata_o,
  output logic [$clog2(N_REQ)-1:0]    grant_id_o,
  output logic [CNT_W-1:0]            conflict_cnt_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             rf_wen_q, rf_wen_d;
  reg_addr_t        rf_waddr_q, rf_waddr_d;
  reg_data_t        rf_wdata_q, rf_wdata_d;
  logic [IdxW-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_any;
  logic             blocked;
  logic             xfer;
  logic             multi_valid;
  reg_addr_t        sel_addr;
  reg_data_t        sel_data;

  rf_wb_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Ready is also masked while in reset so nothing appears granted then.
  assign blocked     = stall_i | flush_i | rst;
  assign req_ready_o = blocked ? '0 : arb_gnt;
  assign xfer        = arb_any & ~blocked;

  // More than one bit set <=> clearing the lowest set bit leaves a nonzero vector.
  assign multi_valid = |(req_valid_i & (req_valid_i - N_REQ'(1)));

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_idx == IdxW'(i)) begin
        sel_addr = req_addr_i[GenbusW*i +: GenbusW];
        sel_data = req_data_i[DatabusW*i +: DatabusW];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    if (xfer) begin
      rr_ptr_d   = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
      // x0 writes are accepted and latched but never enabled.
      rf_wen_d   = (sel_addr != '0);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
      grant_id_d = arb_idx;
    end
    if (multi_valid && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_wen_o       = rf_wen_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign grant_id_o     = grant_id_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (3 requesters, 4-bit conflict counter).
module tb_rf_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic [1:0]      grant_id;
  logic [CW-1:0]   conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .stall_i        (stall),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .rf_wen_o       (rf_wen),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .grant_id_o     (grant_id),
    .conflict_cnt_o (conflict_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic wen, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [1:0] gid);
    chk({tag, ".wen"}, 64'(rf_wen), 64'(wen));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(wa));
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'(wd));
    chk({tag, ".gid"}, 64'(grant_id), 64'(gid));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    req_addr[0 +: 5] = 5'd1; req_data[0 +: 32]  = 32'h0000_0A00;
    req_addr[5 +: 5] = 5'd2; req_data[32 +: 32] = 32'h0000_0B11;
    req_addr[10 +: 5] = 5'd3; req_data[64 +: 32] = 32'h0000_0C22;

    // Reset state, with requests pending
    @(negedge clk);
    chk("rst.ready", 64'(req_ready), 64'(3'b000));
    chk_port("rst", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("rst.cnt", 64'(conflict_cnt), 64'd0);

    // 1: all three valid -> grants rotate 0,1,2,0
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t1.ready0", 64'(req_ready), 64'(3'b001));
    tick(); @(negedge clk);
    chk_port("t1.w0", 1'b1, 5'd1, 32'h0A00, 2'd0);
    chk("t1.ready1", 64'(req_ready), 64'(3'b010));
    chk("t1.cnt1", 64'(conflict_cnt), 64'd1);
    tick(); @(negedge clk);
    chk_port("t1.w1", 1'b1, 5'd2, 32'h0B11, 2'd1);
    chk("t1.ready2", 64'(req_ready), 64'(3'b100));
    tick(); @(negedge clk);
    chk_port("t1.w2", 1'b1, 5'd3, 32'h0C22, 2'd2);
    chk("t1.ready3", 64'(req_ready), 64'(3'b001));
    chk("t1.cnt3", 64'(conflict_cnt), 64'd3);

    // 2: async reset mid-stream, then lone requester 2
    tick();
    rst = 1'b1;
    #1;
    chk_port("t2.arst", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("t2.arst.cnt", 64'(conflict_cnt), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = 3'b100;
    req_addr[10 +: 5] = 5'd5; req_data[64 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2.ready", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk_port("t2.w", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd2);
    chk("t2.cnt", 64'(conflict_cnt), 64'd0);

    // 3: requester 0 writes x0 (ptr wrapped to 0 after requester 2)
    tick();
    req_valid = 3'b001;
    req_addr[0 +: 5] = 5'd0; req_data[0 +: 32] = 32'h0000_0055;
    @(negedge clk);
    chk("t3.ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    chk_port("t3.w", 1'b0, 5'd0, 32'h55, 2'd0);

    // 4: stall 3 cycles with two valid
    tick();
    req_valid = 3'b011;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4.ready", 64'(req_ready), 64'(3'b000));
      chk("t4.wen", 64'(rf_wen), 64'd0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t4.cnt", 64'(conflict_cnt), 64'd3);
    chk("t4.ptr", 64'(req_ready), 64'(3'b010));

    // 5: grant to 1 in t, flush in t+1
    tick();
    flush = 1'b1;
    req_valid = 3'b001;
    @(negedge clk);
    chk_port("t5.w", 1'b1, 5'd2, 32'h0B11, 2'd1);
    chk("t5.ready", 64'(req_ready), 64'(3'b000));
    tick();
    flush = 1'b0;
    req_valid = 3'b000;
    @(negedge clk);
    chk_port("t5.hold", 1'b0, 5'd2, 32'h0B11, 2'd1);
    chk("t5.cnt", 64'(conflict_cnt), 64'd4);

    // 6: counter saturation, then write and async reset
    tick();
    req_valid = 3'b011;
    stall = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        @(negedge clk);
        chk("t6.cnt10", 64'(conflict_cnt), 64'd14);
      end
      tick();
    end
    @(negedge clk);
    chk("t6.sat", 64'(conflict_cnt), 64'd15);
    tick();
    stall = 1'b0;
    req_addr[0 +: 5] = 5'd7;
    @(negedge clk);
    chk("t6.ready", 64'(req_ready), 64'(3'b001));
    tick();
    @(negedge clk);
    chk_port("t6.w", 1'b1, 5'd7, 32'h55, 2'd0);
    chk("t6.sat2", 64'(conflict_cnt), 64'd15);
    rst = 1'b1;
    #1;
    chk_port("t6.arst", 1'b0, 5'd0, 32'd0, 2'd0);
    chk("t6.arst.cnt", 64'(conflict_cnt), 64'd0);
    chk("t6.arst.ready", 64'(req_ready), 64'(3'b000));
    tick();
    rst = 1'b0;
    req_valid = 3'b000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
